// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory signal bundle for mem_arbiter
interface mem_arbiter_if;
  // fetch path
  logic        iReq;
  logic [15:0] iAddr;
  logic        iGnt;
  logic        iValid;
  logic [15:0] iData;
  // data load/store path
  logic        dReq;
  logic        dWe;
  logic [15:0] dAddr;
  logic [15:0] dWData;
  logic        dGnt;
  logic        dValid;
  logic [15:0] dRData;
  // single-port memory
  logic        memCs;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData;
  // pipeline stall
  logic        stall;

  modport slave (
    input  iReq, iAddr, dReq, dWe, dAddr, dWData, memRData,
    output iGnt, iValid, iData, dGnt, dValid, dRData,
           memCs, memWe, memAddr, memWData, stall
  );

  modport master (
    output iReq, iAddr, dReq, dWe, dAddr, dWData, memRData,
    input  iGnt, iValid, iData, dGnt, dValid, dRData,
           memCs, memWe, memAddr, memWData, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one 16-bit memory; MEMARB_STATS_EN adds grant/conflict counters
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int MAX_DBURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
`ifdef MEMARB_STATS_EN
  ,
  output logic [15:0]  statIGrants,
  output logic [15:0]  statDGrants,
  output logic [15:0]  statConflicts
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  localparam logic [3:0] LAT_INIT  = 4'(MEM_LAT - 1);
  localparam logic [3:0] BURST_MAX = 4'(MAX_DBURST);

  logic [1:0]  r_state;
  logic [3:0]  r_lat;
  logic [3:0]  r_burst;
  logic        r_own_d;
  logic        r_iGnt;
  logic        r_dGnt;
  logic        r_iValid;
  logic        r_dValid;
  logic [15:0] r_iData;
  logic [15:0] r_dRData;
  logic        r_memCs;
  logic        r_memWe;
  logic [15:0] r_memAddr;
  logic [15:0] r_memWData;

  logic w_arb;
  logic w_pick_i;
  logic w_done;

  // Arbitrate only in a quiet IDLE cycle: the Valid cycle is a turnaround cycle,
  // which gives the MEM_LAT+2 cycle transaction spacing.
  assign w_arb    = (r_state == S_IDLE) & ~r_iValid & ~r_dValid & (bus.iReq | bus.dReq);
  // Data wins unless fetch has been starved for MAX_DBURST data grants.
  assign w_pick_i = bus.iReq & (~bus.dReq | (r_burst == BURST_MAX));
  // Last edge of the access: memRData is valid and is captured here.
  assign w_done   = ((r_state == S_ACCESS) && (MEM_LAT == 1)) ||
                    ((r_state == S_WAIT) && (r_lat == 4'd1));

  // Transaction sequencer: grant, memory strobe, latency wait and result return.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lat      <= 4'd0;
      r_own_d    <= 1'b0;
      r_iGnt     <= 1'b0;
      r_dGnt     <= 1'b0;
      r_iValid   <= 1'b0;
      r_dValid   <= 1'b0;
      r_iData    <= 16'h0000;
      r_dRData   <= 16'h0000;
      r_memCs    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= 16'h0000;
      r_memWData <= 16'h0000;
    end else begin
      r_iGnt   <= 1'b0;
      r_dGnt   <= 1'b0;
      r_iValid <= 1'b0;
      r_dValid <= 1'b0;
      r_memCs  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_arb) begin
            r_own_d    <= ~w_pick_i;
            r_iGnt     <= w_pick_i;
            r_dGnt     <= ~w_pick_i;
            r_memCs    <= 1'b1;
            r_memWe    <= ~w_pick_i & bus.dWe;
            r_memAddr  <= w_pick_i ? bus.iAddr : bus.dAddr;
            r_memWData <= w_pick_i ? 16'h0000 : bus.dWData;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_lat   <= LAT_INIT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_lat <= r_lat - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_done) begin
        r_state <= S_IDLE;
        if (r_own_d) begin
          r_dValid <= 1'b1;
          if (!r_memWe) r_dRData <= bus.memRData;
        end else begin
          r_iValid <= 1'b1;
          r_iData  <= bus.memRData;
        end
      end
    end
  end

  // Count data grants won while fetch waits; any fetch grant or fetch idle clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst <= 4'd0;
    end else if (w_arb && w_pick_i) begin
      r_burst <= 4'd0;
    end else if (w_arb && bus.iReq) begin
      r_burst <= r_burst + 4'd1;
    end else if ((r_state == S_IDLE) && !bus.iReq) begin
      r_burst <= 4'd0;
    end
  end

`ifdef MEMARB_STATS_EN
  logic [15:0] r_stat_i;
  logic [15:0] r_stat_d;
  logic [15:0] r_stat_c;

  // Free-running wrapping counters of grants and contended arbitrations.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_i <= 16'h0000;
      r_stat_d <= 16'h0000;
      r_stat_c <= 16'h0000;
    end else begin
      if (r_iGnt) r_stat_i <= r_stat_i + 16'h0001;
      if (r_dGnt) r_stat_d <= r_stat_d + 16'h0001;
      if (w_arb && bus.iReq && bus.dReq) r_stat_c <= r_stat_c + 16'h0001;
    end
  end

  assign statIGrants   = r_stat_i;
  assign statDGrants   = r_stat_d;
  assign statConflicts = r_stat_c;
`endif

  assign bus.iGnt     = r_iGnt;
  assign bus.iValid   = r_iValid;
  assign bus.iData    = r_iData;
  assign bus.dGnt     = r_dGnt;
  assign bus.dValid   = r_dValid;
  assign bus.dRData   = r_dRData;
  assign bus.memCs    = r_memCs;
  assign bus.memWe    = r_memWe;
  assign bus.memAddr  = r_memAddr;
  assign bus.memWData = r_memWData;
  assign bus.stall    = (bus.iReq & ~r_iGnt) | (bus.dReq & ~r_dGnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (MEM_LAT 2 and 1 instances)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_if ifa();
  mem_arbiter_if ifb();

`ifdef MEMARB_STATS_EN
  logic [15:0] sa_i, sa_d, sa_c, sb_i, sb_d, sb_c;
`endif

  mem_arbiter #(.MEM_LAT(2), .MAX_DBURST(4)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
`ifdef MEMARB_STATS_EN
    , .statIGrants(sa_i), .statDGrants(sa_d), .statConflicts(sa_c)
`endif
  );

  mem_arbiter #(.MEM_LAT(1), .MAX_DBURST(4)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
`ifdef MEMARB_STATS_EN
    , .statIGrants(sb_i), .statDGrants(sb_d), .statConflicts(sb_c)
`endif
  );

  // Memory models: two-cycle (one read register) for instance a, combinational for b.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] rd_a;

  always @(posedge clk) begin
    if (reset) begin
      mem_a[16'h0010] <= 16'hA5A5;
      rd_a <= 16'h0000;
    end else if (ifa.memCs) begin
      rd_a <= mem_a[ifa.memAddr];
      if (ifa.memWe) mem_a[ifa.memAddr] <= ifa.memWData;
    end
  end
  assign ifa.memRData = rd_a;

  always @(posedge clk) begin
    if (reset) begin
      mem_b[16'h0000] <= 16'h1111;
      mem_b[16'h0001] <= 16'h2222;
    end else if (ifb.memCs && ifb.memWe) begin
      mem_b[ifb.memAddr] <= ifb.memWData;
    end
  end
  assign ifb.memRData = mem_b[ifb.memAddr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({ifa.iGnt, ifa.iValid, ifa.dGnt, ifa.dValid, ifa.memCs, ifa.memWe, ifa.stall,
         ifa.iData, ifa.dRData, ifa.memAddr, ifa.memWData} !== 71'd0)
      $display("FAIL reset_a: got %h want 0", {ifa.iGnt, ifa.iValid, ifa.dGnt, ifa.dValid,
               ifa.memCs, ifa.memWe, ifa.stall, ifa.iData, ifa.dRData, ifa.memAddr, ifa.memWData});
    else n_pass++;
    n_checks++;
    if ({ifb.iGnt, ifb.iValid, ifb.dGnt, ifb.dValid, ifb.memCs, ifb.memWe, ifb.stall,
         ifb.iData, ifb.dRData, ifb.memAddr, ifb.memWData} !== 71'd0)
      $display("FAIL reset_b: got %h want 0", {ifb.iGnt, ifb.iValid, ifb.dGnt, ifb.dValid,
               ifb.memCs, ifb.memWe, ifb.stall, ifb.iData, ifb.dRData, ifb.memAddr, ifb.memWData});
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch;
    ifa.iAddr = 16'h0010;
    ifa.iReq  = 1'b1;
    #1;
    n_checks++;
    if (ifa.stall !== 1'b1) $display("FAIL fetch_stall_pre: got %b want 1", ifa.stall);
    else n_pass++;
    tick();
    n_checks++;
    if ({ifa.iGnt, ifa.dGnt, ifa.memCs, ifa.memWe, ifa.memAddr, ifa.stall} !== {4'b1010, 16'h0010, 1'b0})
      $display("FAIL fetch_gnt: got %h want %h", {ifa.iGnt, ifa.dGnt, ifa.memCs, ifa.memWe, ifa.memAddr, ifa.stall},
               {4'b1010, 16'h0010, 1'b0});
    else n_pass++;
    ifa.iReq = 1'b0;
    tick();
    n_checks++;
    if ({ifa.iGnt, ifa.iValid, ifa.memCs} !== 3'b000)
      $display("FAIL fetch_wait: got %b want 000", {ifa.iGnt, ifa.iValid, ifa.memCs});
    else n_pass++;
    tick();
    n_checks++;
    if ({ifa.iValid, ifa.iData} !== {1'b1, 16'hA5A5})
      $display("FAIL fetch_valid: got %h want 1a5a5", {ifa.iValid, ifa.iData});
    else n_pass++;
    tick();
    n_checks++;
    if (ifa.iValid !== 1'b0) $display("FAIL fetch_valid_pulse: got %b want 0", ifa.iValid);
    else n_pass++;
  endtask

  task automatic test_store;
    ifa.dAddr  = 16'h0200;
    ifa.dWData = 16'h1234;
    ifa.dWe    = 1'b1;
    ifa.dReq   = 1'b1;
    tick();
    n_checks++;
    if ({ifa.dGnt, ifa.iGnt, ifa.memCs, ifa.memWe, ifa.memAddr, ifa.memWData} !== {4'b1011, 16'h0200, 16'h1234})
      $display("FAIL store_gnt: got %h want %h", {ifa.dGnt, ifa.iGnt, ifa.memCs, ifa.memWe, ifa.memAddr, ifa.memWData},
               {4'b1011, 16'h0200, 16'h1234});
    else n_pass++;
    ifa.dReq = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ifa.dValid, ifa.dRData} !== {1'b1, 16'h0000})
      $display("FAIL store_valid: got %h want 10000", {ifa.dValid, ifa.dRData});
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    // new load asserted in the store's Valid cycle
    ifa.dWe  = 1'b0;
    ifa.dReq = 1'b1;
    tick();
    n_checks++;
    if ({ifa.dGnt, ifa.stall} !== 2'b01)
      $display("FAIL b2b_turnaround: got %b want 01", {ifa.dGnt, ifa.stall});
    else n_pass++;
    tick();
    n_checks++;
    if ({ifa.dGnt, ifa.memWe, ifa.memAddr} !== {2'b10, 16'h0200})
      $display("FAIL b2b_load_gnt: got %h want %h", {ifa.dGnt, ifa.memWe, ifa.memAddr}, {2'b10, 16'h0200});
    else n_pass++;
    ifa.dReq = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ifa.dValid, ifa.dRData} !== {1'b1, 16'h1234})
      $display("FAIL b2b_load_data: got %h want 11234", {ifa.dValid, ifa.dRData});
    else n_pass++;
    tick();
  endtask

  task automatic test_burst;
    logic exp_d [10];
    logic got_d [10];
    int   gcyc  [10];
    int   ng;
    int   bad_gap;
    int   cyc;
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ng = 0;
    bad_gap = 0;
`ifdef MEMARB_STATS_EN
    n_checks++;
    if (sa_c !== 16'd0) $display("FAIL stats_conflicts_pre: got %0d want 0", sa_c);
    else n_pass++;
`endif
    ifa.iAddr = 16'h0010;
    ifa.dAddr = 16'h0200;
    ifa.dWe   = 1'b0;
    ifa.iReq  = 1'b1;
    ifa.dReq  = 1'b1;
    #1;
    n_checks++;
    if (ifa.stall !== 1'b1) $display("FAIL burst_stall: got %b want 1", ifa.stall);
    else n_pass++;
    for (cyc = 0; cyc < 100 && ng < 10; cyc++) begin
      tick();
      if (ifa.iGnt || ifa.dGnt) begin
        got_d[ng] = ifa.dGnt;
        gcyc[ng]  = cyc;
        ng++;
      end
    end
    ifa.iReq = 1'b0;
    ifa.dReq = 1'b0;
    n_checks++;
    if (ng != 10) $display("FAIL burst_timeout: got %0d grants want 10", ng);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      if (k < ng) begin
        n_checks++;
        if (got_d[k] !== exp_d[k])
          $display("FAIL burst_order[%0d]: got dGnt=%b want %b", k, got_d[k], exp_d[k]);
        else n_pass++;
        if (k > 0 && gcyc[k] - gcyc[k-1] != 4) bad_gap++;
      end
    end
    n_checks++;
    if (bad_gap != 0) $display("FAIL burst_spacing: got %0d gaps not 4 cycles want 0", bad_gap);
    else n_pass++;
    for (int k = 0; k < 6; k++) tick();
`ifdef MEMARB_STATS_EN
    n_checks++;
    if ({sa_i, sa_d, sa_c} !== {16'd3, 16'd10, 16'd10})
      $display("FAIL stats_counts: got %0d %0d %0d want 3 10 10", sa_i, sa_d, sa_c);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_midflight;
    int seen;
    seen = 0;
    ifa.dAddr = 16'h0200;
    ifa.dWe   = 1'b0;
    ifa.dReq  = 1'b1;
    tick();
    n_checks++;
    if (ifa.dGnt !== 1'b1) $display("FAIL mid_gnt: got %b want 1", ifa.dGnt);
    else n_pass++;
    ifa.dReq = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({ifa.iGnt, ifa.iValid, ifa.dGnt, ifa.dValid, ifa.memCs, ifa.memWe,
         ifa.iData, ifa.dRData, ifa.memAddr, ifa.memWData} !== 70'd0)
      $display("FAIL mid_reset_outputs: got %h want 0", {ifa.iGnt, ifa.iValid, ifa.dGnt, ifa.dValid,
               ifa.memCs, ifa.memWe, ifa.iData, ifa.dRData, ifa.memAddr, ifa.memWData});
    else n_pass++;
`ifdef MEMARB_STATS_EN
    n_checks++;
    if ({sa_i, sa_d, sa_c} !== 48'd0) $display("FAIL stats_reset: got %h want 0", {sa_i, sa_d, sa_c});
    else n_pass++;
`endif
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ifa.dValid) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL mid_no_valid: got %0d dValid pulses want 0", seen);
    else n_pass++;
    ifa.iAddr = 16'h0010;
    ifa.iReq  = 1'b1;
    tick();
    n_checks++;
    if ({ifa.iGnt, ifa.memAddr} !== {1'b1, 16'h0010})
      $display("FAIL mid_after_gnt: got %h want 10010", {ifa.iGnt, ifa.memAddr});
    else n_pass++;
    ifa.iReq = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ifa.iValid, ifa.iData} !== {1'b1, 16'hA5A5})
      $display("FAIL mid_after_data: got %h want 1a5a5", {ifa.iValid, ifa.iData});
    else n_pass++;
    tick();
  endtask

  task automatic test_lat1;
    ifb.iAddr = 16'h0000;
    ifb.iReq  = 1'b1;
    tick();
    n_checks++;
    if ({ifb.iGnt, ifb.memCs, ifb.memAddr} !== {2'b11, 16'h0000})
      $display("FAIL lat1_gnt0: got %h want 30000", {ifb.iGnt, ifb.memCs, ifb.memAddr});
    else n_pass++;
    ifb.iAddr = 16'h0001;
    tick();
    n_checks++;
    if ({ifb.iGnt, ifb.iValid, ifb.iData} !== {2'b01, 16'h1111})
      $display("FAIL lat1_valid0: got %h want 11111", {ifb.iGnt, ifb.iValid, ifb.iData});
    else n_pass++;
    tick();
    n_checks++;
    if ({ifb.iGnt, ifb.iValid} !== 2'b00)
      $display("FAIL lat1_gap: got %b want 00", {ifb.iGnt, ifb.iValid});
    else n_pass++;
    tick();
    n_checks++;
    if ({ifb.iGnt, ifb.memAddr} !== {1'b1, 16'h0001})
      $display("FAIL lat1_gnt1: got %h want 10001", {ifb.iGnt, ifb.memAddr});
    else n_pass++;
    ifb.iReq = 1'b0;
    tick();
    n_checks++;
    if ({ifb.iValid, ifb.iData} !== {1'b1, 16'h2222})
      $display("FAIL lat1_valid1: got %h want 12222", {ifb.iValid, ifb.iData});
    else n_pass++;
    tick();
  endtask

  initial begin
    ifa.iReq = 1'b0; ifa.iAddr = 16'h0; ifa.dReq = 1'b0; ifa.dWe = 1'b0;
    ifa.dAddr = 16'h0; ifa.dWData = 16'h0;
    ifb.iReq = 1'b0; ifb.iAddr = 16'h0; ifb.dReq = 1'b0; ifb.dWe = 1'b0;
    ifb.dAddr = 16'h0; ifb.dWData = 16'h0;
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_burst();
    test_reset_midflight();
    test_lat1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
